// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus responder: register map, transmit
// FSM states and the reset baud divisor.
package spart_pkg;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    // 9600 baud at 50 MHz with 16x oversampling
    localparam logic [15:0] DIV_RESET_DEF = 16'h0145;
    localparam int          OVERSAMPLE_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Counter reload value: divisor 0 and 1 both mean "tick every cycle".
    function automatic logic [15:0] dec_sat(input logic [15:0] v);
        return (v == 16'd0) ? 16'd0 : v - 16'd1;
    endfunction

endpackage

// File: rtl/spart_baud_gen.sv
// Programmable divisor and down-counter producing the 16x baud enable.
module spart_baud_gen
    import spart_pkg::*;
#(
    parameter logic [15:0] DIV_RESET = DIV_RESET_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [7:0]  wr_data,
    output logic [15:0] divisor,
    output logic        baud_en
);

    logic [15:0] divisor_q, divisor_d;
    logic [15:0] cnt_q, cnt_d;

    assign divisor = divisor_q;
    assign baud_en = (cnt_q == 16'd0);

    always_comb begin
        divisor_d = divisor_q;
        if (wr_lo) divisor_d[7:0]  = wr_data;
        if (wr_hi) divisor_d[15:8] = wr_data;
    end

    // A high-byte write restarts the period; a low-byte write only affects
    // the next natural reload.
    always_comb begin
        cnt_d = cnt_q - 16'd1;
        if (wr_hi) begin
            cnt_d = dec_sat({wr_data, divisor_q[7:0]});
        end else if (cnt_q == 16'd0) begin
            cnt_d = dec_sat(divisor_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divisor_q <= DIV_RESET;
            cnt_q     <= dec_sat(DIV_RESET);
        end else begin
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/spart_bus_tx.sv
// SPART bus responder: register decode, 8N1 transmitter and receive buffer.
// Reads drive databus combinationally while iocs=1 and iorw=1.
module spart_bus_tx
    import spart_pkg::*;
#(
    parameter logic [15:0] DIV_RESET  = DIV_RESET_DEF,
    parameter int          OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       baud_en
);

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

    logic        bus_wr, bus_rd;
    logic        wr_buf, rd_buf;
    logic [15:0] divisor;
    logic [7:0]  rd_data;

    assign bus_wr = iocs & ~iorw;
    assign bus_rd = iocs & iorw;
    assign wr_buf = bus_wr && (ioaddr == ADDR_BUF);
    assign rd_buf = bus_rd && (ioaddr == ADDR_BUF);

    spart_baud_gen #(.DIV_RESET(DIV_RESET)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .wr_lo   (bus_wr && (ioaddr == ADDR_DBL)),
        .wr_hi   (bus_wr && (ioaddr == ADDR_DBH)),
        .wr_data (databus),
        .divisor (divisor),
        .baud_en (baud_en)
    );

    tx_state_t  tx_state_q, tx_state_d;
    logic [3:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;

    assign tbr = (tx_state_q == IDLE);

    // A buffer write is only accepted from IDLE; otherwise the byte is dropped.
    always_comb begin
        tx_state_d = tx_state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        if (tx_state_q == IDLE) begin
            if (wr_buf) begin
                tx_state_d = START;
                tick_d     = 4'd0;
                bit_d      = 3'd0;
                shift_d    = databus;
            end
        end else if (baud_en) begin
            tick_d = tick_q + 4'd1;
            if (tick_q == TICK_LAST) begin
                tick_d = 4'd0;
                case (tx_state_q)
                    START: tx_state_d = DATA;
                    DATA: begin
                        if (bit_q == 3'd7) tx_state_d = STOP;
                        else               bit_d      = bit_q + 3'd1;
                    end
                    STOP:    tx_state_d = IDLE;
                    default: tx_state_d = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        case (tx_state_q)
            START:   txd = 1'b0;
            DATA:    txd = shift_q[bit_q];
            default: txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= IDLE;
            tick_q     <= 4'd0;
            bit_q      <= 3'd0;
            shift_q    <= 8'd0;
        end else begin
            tx_state_q <= tx_state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
        end
    end

    logic [7:0] rx_buf_q, rx_buf_d;
    logic       rda_q, rda_d;

    assign rda = rda_q;

    // A new byte wins over a simultaneous read, so rda stays set.
    always_comb begin
        rx_buf_d = rx_buf_q;
        rda_d    = rda_q;
        if (rx_valid) begin
            rx_buf_d = rx_data;
            rda_d    = 1'b1;
        end else if (rd_buf) begin
            rda_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_buf_q <= 8'd0;
            rda_q    <= 1'b0;
        end else begin
            rx_buf_q <= rx_buf_d;
            rda_q    <= rda_d;
        end
    end

    always_comb begin
        case (ioaddr)
            ADDR_BUF:  rd_data = rx_buf_q;
            ADDR_STAT: rd_data = {6'b0, tbr, rda_q};
            ADDR_DBL:  rd_data = divisor[7:0];
            default:   rd_data = divisor[15:8];
        endcase
    end

    assign databus = bus_rd ? rd_data : 8'bz;

endmodule

// File: tb/tb_spart_bus_tx.sv
// Bench for spart_bus_tx: directed scenarios with literal expectations plus
// randomized bus/rx traffic checked every cycle against a behavioural model.
module tb_spart_bus_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] tb_wdata = 8'h00;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  wire  [7:0] databus;
  logic       rda, tbr, txd, baud_en;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  assign databus = (iocs && !iorw) ? tb_wdata : 8'bz;

  spart_bus_tx dut (
    .clk      (clk),
    .rst      (rst),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .databus  (databus),
    .rda      (rda),
    .tbr      (tbr),
    .txd      (txd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .baud_en  (baud_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int period(input logic [15:0] d);
    return (d < 16'd2) ? 1 : int'(d);
  endfunction

  // ---------------- behavioural model ----------------
  // Baud ticks are modelled as absolute cycle numbers; the serial frame as a
  // queue of line levels, each held for 16 ticks.
  int          next_tick;
  logic [15:0] m_div;
  logic [0:0]  exp_q[$];
  int          m_n;
  logic [7:0]  m_buf;
  logic        m_rda;

  always @(negedge clk) begin : cmp
    logic        exp_be, exp_tbr, exp_txd, was_idle;
    logic [7:0]  exp_rd;
    logic [15:0] new_div;
    cyc++;
    if (!rst) begin
      check("rst_txd", 16'(txd), 16'd1);
      check("rst_tbr", 16'(tbr), 16'd1);
      check("rst_rda", 16'(rda), 16'd0);
      check("rst_baud_en", 16'(baud_en), 16'd0);
      m_div = 16'h0145;
      next_tick = cyc + 1 + 16'h0144;
      exp_q.delete();
      m_n = 0;
      m_buf = 8'h00;
      m_rda = 1'b0;
    end else begin
      exp_be  = (cyc == next_tick);
      exp_tbr = (exp_q.size() == 0);
      exp_txd = exp_tbr ? 1'b1 : exp_q[0];
      was_idle = exp_tbr;
      check("baud_en", 16'(baud_en), 16'(exp_be));
      check("txd", 16'(txd), 16'(exp_txd));
      check("tbr", 16'(tbr), 16'(exp_tbr));
      check("rda", 16'(rda), 16'(m_rda));
      if (iocs && iorw) begin
        case (ioaddr)
          2'b00:   exp_rd = m_buf;
          2'b01:   exp_rd = {6'b0, exp_tbr, m_rda};
          2'b10:   exp_rd = m_div[7:0];
          default: exp_rd = m_div[15:8];
        endcase
        check("read_data", 16'(databus), 16'(exp_rd));
      end
      // transmit
      if (!was_idle && exp_be) begin
        m_n++;
        if (m_n == 16) begin
          void'(exp_q.pop_front());
          m_n = 0;
        end
      end else if (was_idle && iocs && !iorw && ioaddr == 2'b00) begin
        exp_q.push_back(1'b0);
        for (int b = 0; b < 8; b++) exp_q.push_back(tb_wdata[b]);
        exp_q.push_back(1'b1);
        m_n = 0;
      end
      // baud / divisor
      if (iocs && !iorw && ioaddr == 2'b11) begin
        new_div = {tb_wdata, m_div[7:0]};
        next_tick = cyc + period(new_div);
        m_div = new_div;
      end else begin
        if (exp_be) next_tick = cyc + period(m_div);
        if (iocs && !iorw && ioaddr == 2'b10) m_div[7:0] = tb_wdata;
      end
      // receive buffer
      if (rx_valid) begin
        m_buf = rx_data;
        m_rda = 1'b1;
      end else if (iocs && iorw && ioaddr == 2'b00) begin
        m_rda = 1'b0;
      end
    end
  end

  // ---------------- driver tasks (enter/leave at posedge+1) ----------------
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_wdata = d;
    @(posedge clk); #1;
    iocs = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    @(negedge clk);
    d = databus;
    @(posedge clk); #1;
    iocs = 1'b0; iorw = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    rx_valid = 1'b1; rx_data = d;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_first_tick(output int found);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (baud_en) found = 1;
    end
    check("first_tick_seen", 16'(found), 16'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] d;
    logic [9:0] seq;
    int found, off;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // reset register values
    bus_read(2'b01, d); check("status_after_reset", 16'(d), 16'h02);
    bus_read(2'b10, d); check("div_lo_after_reset", 16'(d), 16'h45);
    bus_read(2'b11, d); check("div_hi_after_reset", 16'(d), 16'h01);

    // divisor 4: ticks 4 cycles after the high-byte write, then every 4
    bus_write(2'b10, 8'h04);
    bus_write(2'b11, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("div4_tick", 16'(baud_en), 16'((i % 4) == 0));
    end
    @(posedge clk); #1;
    bus_write(2'b10, 8'h00);
    bus_write(2'b11, 8'h00);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("div0_tick", 16'(baud_en), 16'd1);
    end
    @(posedge clk); #1;
    bus_write(2'b10, 8'h04);
    bus_write(2'b11, 8'h00);

    // frame of 8'hA5 with a dropped mid-frame write of 8'hFF
    bus_write(2'b00, 8'hA5);
    fork
      begin
        repeat (300) @(posedge clk);
        #1 bus_write(2'b00, 8'hFF);
      end
    join_none
    seq = 10'b1101001010;
    wait_first_tick(found);
    off = 0;
    for (int k = 0; k < 10; k++) begin
      repeat (64 * k + 30 - off) @(negedge clk);
      off = 64 * k + 30;
      check("a5_txd_bit", 16'(txd), 16'(seq[k]));
      check("a5_tbr_busy", 16'(tbr), 16'd0);
    end
    repeat (636 - off) @(negedge clk);
    check("a5_tbr_last_busy", 16'(tbr), 16'd0);
    @(negedge clk);
    check("a5_tbr_back", 16'(tbr), 16'd1);
    @(posedge clk); #1;
    idle(100);

    // receive buffer
    rx_pulse(8'h3C);
    bus_read(2'b01, d); check("status_rda", 16'(d), 16'h03);
    bus_read(2'b00, d); check("rx_read_3c", 16'(d), 16'h3C);
    @(negedge clk); check("rda_cleared", 16'(rda), 16'd0);
    @(posedge clk); #1;
    rx_pulse(8'h77);
    rx_pulse(8'h11);
    bus_read(2'b00, d); check("rx_overrun_11", 16'(d), 16'h11);

    // simultaneous read and new byte
    rx_pulse(8'hC3);
    iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00; rx_valid = 1'b1; rx_data = 8'h5A;
    @(negedge clk);
    check("simul_read_old", 16'(databus), 16'hC3);
    @(posedge clk); #1;
    iocs = 1'b0; iorw = 1'b0; rx_valid = 1'b0;
    @(negedge clk); check("simul_rda_kept", 16'(rda), 16'd1);
    @(posedge clk); #1;
    bus_read(2'b00, d); check("simul_next_5a", 16'(d), 16'h5A);

    // reset during data bit 3 of 8'h96 (bit 3 is 0)
    bus_write(2'b00, 8'h96);
    wait_first_tick(found);
    repeat (64 * 4 + 30) @(negedge clk);
    check("pre_reset_txd", 16'(txd), 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("async_rst_txd", 16'(txd), 16'd1);
    check("async_rst_tbr", 16'(tbr), 16'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    bus_read(2'b10, d); check("post_rst_div_lo", 16'(d), 16'h45);
    bus_read(2'b11, d); check("post_rst_div_hi", 16'(d), 16'h01);
    idle(200);

    // randomized traffic with small divisors
    bus_write(2'b10, 8'h03);
    bus_write(2'b11, 8'h00);
    for (int i = 0; i < 4000; i++) begin
      iocs = ($urandom_range(0, 9) < 3);
      iorw = 1'($urandom_range(0, 1));
      ioaddr = 2'($urandom_range(0, 3));
      if (ioaddr == 2'b11)      tb_wdata = 8'h00;
      else if (ioaddr == 2'b10) tb_wdata = 8'($urandom_range(0, 6));
      else                      tb_wdata = 8'($urandom_range(0, 255));
      rx_valid = ($urandom_range(0, 9) == 0);
      rx_data = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
    iocs = 1'b0; iorw = 1'b0; rx_valid = 1'b0;
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
